// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings, flag indices, FSM state and the instruction decoder for datapath_ctrl.
// Bcond decoding is enabled by DATAPATH_CTRL_BRANCH_EN.
package datapath_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_N   = 16;
  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned OP_W    = 8;

  localparam logic [3:0] OPC_RTYPE = 4'h0;
  localparam logic [3:0] OPC_BCOND = 4'hC;
  localparam logic [3:0] OPC_LUI   = 4'hF;

  localparam logic [3:0] FN_AND  = 4'h1;
  localparam logic [3:0] FN_OR   = 4'h2;
  localparam logic [3:0] FN_XOR  = 4'h3;
  localparam logic [3:0] FN_ADD  = 4'h5;
  localparam logic [3:0] FN_ADDC = 4'h7;
  localparam logic [3:0] FN_SUB  = 4'h9;
  localparam logic [3:0] FN_CMP  = 4'hB;
  localparam logic [3:0] FN_MOV  = 4'hD;

  localparam logic [3:0] CC_EQ   = 4'h0;
  localparam logic [3:0] CC_NE   = 4'h1;
  localparam logic [3:0] CC_CS   = 4'h2;
  localparam logic [3:0] CC_CC   = 4'h3;
  localparam logic [3:0] CC_FS   = 4'h4;
  localparam logic [3:0] CC_FC   = 4'h5;
  localparam logic [3:0] CC_GT   = 4'h6;
  localparam logic [3:0] CC_LE   = 4'h7;
  localparam logic [3:0] CC_RSV0 = 4'h8;
  localparam logic [3:0] CC_RSV1 = 4'h9;
  localparam logic [3:0] CC_LO   = 4'hA;
  localparam logic [3:0] CC_HS   = 4'hB;
  localparam logic [3:0] CC_LT   = 4'hC;
  localparam logic [3:0] CC_GE   = 4'hD;
  localparam logic [3:0] CC_UC   = 4'hE;
  localparam logic [3:0] CC_NV   = 4'hF;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXEC} state_t;

  typedef struct packed {
    logic               legal;
    logic               branch;
    logic               wr;
    logic               set_flags;
    logic               use_cin;
    logic               imm_sel;
    logic [3:0]         a_sel;
    logic [3:0]         b_sel;
    logic [3:0]         func;
    logic [INSTR_W-1:0] immediate;
  } dec_t;

  function automatic logic is_alu_func(input logic [3:0] f);
    case (f)
      FN_AND, FN_OR, FN_XOR, FN_ADD, FN_ADDC, FN_SUB, FN_CMP, FN_MOV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_flag_func(input logic [3:0] f);
    return (f == FN_ADD) || (f == FN_ADDC) || (f == FN_SUB) || (f == FN_CMP);
  endfunction

  // Illegal encodings decode to all-zero controls, i.e. a NOP.
  function automatic dec_t decode(input logic [INSTR_W-1:0] ins);
    dec_t       d;
    logic [3:0] opc;
    d   = '0;
    opc = ins[15:12];
    if (opc == OPC_RTYPE) begin
      if (is_alu_func(ins[7:4])) begin
        d.legal = 1'b1;
        d.a_sel = ins[11:8];
        d.b_sel = ins[3:0];
        d.func  = ins[7:4];
      end
    end else if (opc == OPC_LUI) begin
      d.legal     = 1'b1;
      d.a_sel     = ins[11:8];
      d.imm_sel   = 1'b1;
      d.func      = FN_MOV;
      d.immediate = {ins[7:0], 8'h00};
    end else if (opc == OPC_BCOND) begin
`ifdef DATAPATH_CTRL_BRANCH_EN
      d.legal  = (ins[11:8] != CC_RSV0) && (ins[11:8] != CC_RSV1);
      d.branch = d.legal;
`endif
    end else if (is_alu_func(opc)) begin
      d.legal     = 1'b1;
      d.a_sel     = ins[11:8];
      d.imm_sel   = 1'b1;
      d.func      = opc;
      d.immediate = is_flag_func(opc) ? {{8{ins[7]}}, ins[7:0]} : {8'h00, ins[7:0]};
    end
    if (d.legal && !d.branch) begin
      d.wr        = (d.func != FN_CMP);
      d.set_flags = is_flag_func(d.func);
      d.use_cin   = (d.func == FN_ADDC);
    end
    return d;
  endfunction

endpackage

// File: rtl/datapath_ctrl_cond_eval.sv
// Branch condition evaluator: {cond, latched flags} -> taken.
// Only built when DATAPATH_CTRL_BRANCH_EN is defined.
`ifdef DATAPATH_CTRL_BRANCH_EN
module cond_eval
  import datapath_ctrl_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = flags[FLAG_Z];
      CC_NE:   taken = !flags[FLAG_Z];
      CC_CS:   taken = flags[FLAG_C];
      CC_CC:   taken = !flags[FLAG_C];
      CC_FS:   taken = flags[FLAG_F];
      CC_FC:   taken = !flags[FLAG_F];
      CC_GT:   taken = flags[FLAG_N];
      CC_LE:   taken = !flags[FLAG_N];
      CC_LO:   taken = flags[FLAG_L];
      CC_HS:   taken = !flags[FLAG_L];
      CC_LT:   taken = !flags[FLAG_N] && !flags[FLAG_Z];
      CC_GE:   taken = flags[FLAG_N] || flags[FLAG_Z];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/datapath_ctrl.sv
// Three-state fetch/decode/exec controller driving the register-bank/ALU datapath.
// DATAPATH_CTRL_BRANCH_EN enables Bcond; otherwise opcode 1100 is illegal.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [PC_W-1:0]      pc,
  input  logic [FLAG_W-1:0]    flags,
  output logic [3:0]           a_sel,
  output logic [3:0]           b_sel,
  output logic [OP_W-1:0]      op,
  output logic                 cin,
  output logic                 imm_sel,
  output logic [INSTR_W-1:0]   immediate,
  output logic                 tri_en,
  output logic [REG_N-1:0]     reg_en,
  output logic                 illegal
);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [FLAG_W-1:0]   flag_q, flag_d;
  logic [3:0]          a_sel_q, a_sel_d;
  logic [3:0]          b_sel_q, b_sel_d;
  logic [3:0]          func_q, func_d;
  logic                cin_q, cin_d;
  logic                imm_sel_q, imm_sel_d;
  logic [INSTR_W-1:0]  immediate_q, immediate_d;
  logic                tri_en_q, tri_en_d;
  logic [REG_N-1:0]    reg_en_q, reg_en_d;
  logic                illegal_q, illegal_d;

  dec_t                dec_c;
  logic                taken_c;
  logic [PC_W-1:0]     disp_ext_c;

  // One decoder: the incoming word while fetching, the held IR afterwards.
  assign dec_c      = decode((state_q == ST_FETCH) ? instr : ir_q);
  assign disp_ext_c = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};

`ifdef DATAPATH_CTRL_BRANCH_EN
  cond_eval u_cond_eval (
    .cond  (ir_q[11:8]),
    .flags (flag_q),
    .taken (taken_c)
  );
`else
  assign taken_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flag_d      = flag_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    func_d      = func_q;
    cin_d       = cin_q;
    imm_sel_d   = imm_sel_q;
    immediate_d = immediate_q;
    tri_en_d    = 1'b0;
    reg_en_d    = '0;
    illegal_d   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d        = instr;
          a_sel_d     = dec_c.a_sel;
          b_sel_d     = dec_c.b_sel;
          func_d      = dec_c.func;
          cin_d       = dec_c.use_cin & flag_q[FLAG_C];
          imm_sel_d   = dec_c.imm_sel;
          immediate_d = dec_c.immediate;
          illegal_d   = !dec_c.legal;
          state_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        tri_en_d = dec_c.legal && !dec_c.branch;
        reg_en_d = dec_c.wr ? (REG_N'(1) << dec_c.a_sel) : '0;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_c.set_flags) flag_d = flags;
        pc_d        = (dec_c.branch && taken_c) ? (pc_q + disp_ext_c) : (pc_q + PC_W'(1));
        a_sel_d     = '0;
        b_sel_d     = '0;
        func_d      = '0;
        cin_d       = 1'b0;
        imm_sel_d   = 1'b0;
        immediate_d = '0;
        state_d     = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      flag_q      <= '0;
      a_sel_q     <= '0;
      b_sel_q     <= '0;
      func_q      <= '0;
      cin_q       <= 1'b0;
      imm_sel_q   <= 1'b0;
      immediate_q <= '0;
      tri_en_q    <= 1'b0;
      reg_en_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      flag_q      <= flag_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      func_q      <= func_d;
      cin_q       <= cin_d;
      imm_sel_q   <= imm_sel_d;
      immediate_q <= immediate_d;
      tri_en_q    <= tri_en_d;
      reg_en_q    <= reg_en_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_ready = (state_q == ST_FETCH);
  assign pc          = pc_q;
  assign a_sel       = a_sel_q;
  assign b_sel       = b_sel_q;
  assign op          = {4'h0, func_q};
  assign cin         = cin_q;
  assign imm_sel     = imm_sel_q;
  assign immediate   = immediate_q;
  assign tri_en      = tri_en_q;
  assign reg_en      = reg_en_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed self-checking bench for datapath_ctrl (default build and DATAPATH_CTRL_BRANCH_EN).
module tb_datapath_ctrl;

  logic        clk;
  logic        Reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic [4:0]  flags;
  logic [3:0]  a_sel, b_sel;
  logic [7:0]  op;
  logic        cin, imm_sel, tri_en, illegal;
  logic [15:0] immediate, reg_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Values captured during DECODE and EXEC by run_instr.
  logic [3:0]  d_a, d_b;
  logic [7:0]  d_op;
  logic        d_cin, d_isel, d_ill;
  logic [15:0] d_imm;
  logic        e_tri, e_ill;
  logic [15:0] e_reg;

  datapath_ctrl #(.PC_W(16)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .flags       (flags),
    .a_sel       (a_sel),
    .b_sel       (b_sel),
    .op          (op),
    .cin         (cin),
    .imm_sel     (imm_sel),
    .immediate   (immediate),
    .tri_en      (tri_en),
    .reg_en      (reg_en),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  // Issue one instruction from a negedge in FETCH; returns at the negedge back in FETCH.
  task automatic run_instr(input logic [15:0] ins, input logic [4:0] flg);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
    instr       = ins;
    flags       = flg;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    d_a = a_sel; d_b = b_sel; d_op = op; d_cin = cin;
    d_isel = imm_sel; d_imm = immediate; d_ill = illegal;
    @(negedge clk);
    e_tri = tri_en; e_reg = reg_en; e_ill = illegal;
    @(negedge clk);
  endtask

  initial begin
    Reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    flags       = '0;
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_outs", {reg_en, immediate}, 32'd0);
    check("rst_ctl", {20'd0, tri_en, illegal, imm_sel, cin, op}, 32'd0);
    Reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 32'd1);

    // MOVI R3, 0x85
    run_instr(16'hD385, 5'b00000);
    check("movi_isel", 32'(d_isel), 32'd1);
    check("movi_imm", 32'(d_imm), 32'h0085);
    check("movi_op", 32'(d_op), 32'h0D);
    check("movi_asel", 32'(d_a), 32'd3);
    check("movi_reg_en", 32'(e_reg), 32'h0008);
    check("movi_tri", 32'(e_tri), 32'd1);
    check("movi_pc", 32'(pc), 32'd1);
    check("fetch_zero", {reg_en, immediate}, 32'd0);
    check("fetch_tri", 32'(tri_en), 32'd0);

    // ADDI R1, -1
    run_instr(16'h51FF, 5'b00000);
    check("addi_imm", 32'(d_imm), 32'hFFFF);
    check("addi_op", 32'(d_op), 32'h05);
    check("addi_reg_en", 32'(e_reg), 32'h0002);

    // ADD R2,R4 returning C=1, then ADDC picks up the carry
    run_instr(16'h0254, 5'b00001);
    check("add_sel", {24'd0, d_a, d_b}, 32'h24);
    check("add_isel", 32'(d_isel), 32'd0);
    check("add_op", 32'(d_op), 32'h05);
    check("add_cin", 32'(d_cin), 32'd0);
    check("add_reg_en", 32'(e_reg), 32'h0004);
    run_instr(16'h0274, 5'b00000);
    check("addc_op", 32'(d_op), 32'h07);
    check("addc_cin", 32'(d_cin), 32'd1);
    check("addc_pc", 32'(pc), 32'd4);

    // LUI R5, 0xAB and ANDI R2, 0xF0 (zero-extend)
    run_instr(16'hF5AB, 5'b00000);
    check("lui_imm", 32'(d_imm), 32'hAB00);
    check("lui_op", 32'(d_op), 32'h0D);
    check("lui_reg_en", 32'(e_reg), 32'h0020);
    run_instr(16'h12F0, 5'b00000);
    check("andi_imm", 32'(d_imm), 32'h00F0);
    check("andi_op", 32'(d_op), 32'h01);

    // Illegal R-type ext and illegal opcode behave as NOPs
    run_instr(16'h0040, 5'b00000);
    check("ill_rtype", 32'(d_ill), 32'd1);
    check("ill_rtype_pulse", 32'(e_ill), 32'd0);
    check("ill_rtype_exec", {15'd0, e_tri, e_reg}, 32'd0);
    run_instr(16'h4000, 5'b00000);
    check("ill_opc", 32'(d_ill), 32'd1);
    check("ill_opc_pc", 32'(pc), 32'd8);

    // CMP R1,R2 with Z set: no register write
    run_instr(16'h01B2, 5'b01000);
    check("cmp_op", 32'(d_op), 32'h0B);
    check("cmp_reg_en", 32'(e_reg), 32'h0000);
    check("cmp_pc", 32'(pc), 32'd9);

`ifdef DATAPATH_CTRL_BRANCH_EN
    run_instr(16'hC004, 5'b00000);
    check("beq_taken_exec", {15'd0, e_tri, e_reg}, 32'd0);
    check("beq_taken_pc", 32'(pc), 32'd13);
    run_instr(16'h01B2, 5'b00000);
    run_instr(16'hC004, 5'b00000);
    check("beq_not_taken_pc", 32'(pc), 32'd15);
`else
    run_instr(16'hC004, 5'b00000);
    check("bcond_illegal", 32'(d_ill), 32'd1);
    check("bcond_illegal_pc", 32'(pc), 32'd10);
`endif

    // Reset during EXEC of ADD R7,R1: write enables drop without a clock edge
    instr       = 16'h0751;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("rst_exec_reg_en_pre", 32'(reg_en), 32'h0080);
    #2 Reset = 1'b1;
    #1;
    check("rst_exec_reg_en", 32'(reg_en), 32'h0000);
    check("rst_exec_tri", 32'(tri_en), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    #1;
    check("rst_exec_ready", 32'(instr_ready), 32'd1);
    check("rst_exec_pc", 32'(pc), 32'd0);

    // instr_valid held high through DECODE with a different word must not latch
    @(negedge clk);
    instr       = 16'hD111;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = 16'hD2FF;
    @(negedge clk);
    instr_valid = 1'b0;
    check("hold_imm", 32'(immediate), 32'h0011);
    check("hold_reg_en", 32'(reg_en), 32'h0002);
    @(negedge clk);
    check("hold_pc", 32'(pc), 32'd1);
    check("hold_ready", 32'(instr_ready), 32'd1);

    do_reset();
`ifdef DATAPATH_CTRL_BRANCH_EN
    run_instr(16'hCEFE, 5'b00000);
    check("buc_wrap_pc", 32'(pc), 32'hFFFE);
    run_instr(16'hC800, 5'b00000);
    check("bcond_rsv_ill", 32'(d_ill), 32'd1);
    check("bcond_rsv_pc", 32'(pc), 32'hFFFF);
    run_instr(16'hCF10, 5'b00000);
    check("bnv_wrap_pc", 32'(pc), 32'h0000);
`else
    run_instr(16'hCEFE, 5'b00000);
    check("buc_ill", 32'(d_ill), 32'd1);
    check("buc_ill_exec", {15'd0, e_tri, e_reg}, 32'd0);
    check("buc_ill_pc", 32'(pc), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=0x0 exp=0x1");
    $fatal(1, "timeout");
  end

endmodule
